// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: registered tristate output path, synchronised input path and
// sticky per-pin edge interrupts. Define GPIO_PAD_BANK_FILTER_EN for the input glitch filter.
module gpio_pad_bank #(
  parameter int WIDTH         = 32,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             io_clock,
  input  logic             io_resetn,
  input  logic [WIDTH-1:0] core_write,
  input  logic [WIDTH-1:0] core_writeEnable,
  output logic [WIDTH-1:0] core_read,
  input  logic [WIDTH-1:0] pad_o,
  output logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] pad_t,
  input  logic [WIDTH-1:0] irq_rise_mask,
  input  logic [WIDTH-1:0] irq_fall_mask,
  input  logic [WIDTH-1:0] irq_clear,
  output logic [WIDTH-1:0] irq_pending,
  output logic             irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + FILTER_CYCLES + 2);
`ifdef GPIO_PAD_BANK_FILTER_EN
  localparam int ARM_LEN = SYNC_STAGES + 1 + FILTER_CYCLES;
`else
  localparam int ARM_LEN = SYNC_STAGES + 1;
`endif
  localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [0:0] {
    DISARMED = 1'b0,
    ARMED    = 1'b1
  } arm_state_t;

  arm_state_t       arm_state_r;
  logic [CNT_W-1:0] arm_cnt_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic [WIDTH-1:0] prev_r;
  logic [WIDTH-1:0] in_val_s;
  logic [WIDTH-1:0] set_s;

  // Drive value and enable share one register stage; input synchroniser chain.
  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      pad_i <= '0;
      pad_t <= '1;
      for (int s = 0; s < SYNC_STAGES; s++) sync_r[s] <= '0;
    end else begin
      pad_i     <= core_write;
      pad_t     <= ~core_writeEnable;
      sync_r[0] <= pad_o;
      for (int s = 1; s < SYNC_STAGES; s++) sync_r[s] <= sync_r[s-1];
    end
  end

`ifdef GPIO_PAD_BANK_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CYCLES - 1);
  localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1);

  logic [FLT_W-1:0] flt_cnt_r [WIDTH];
  logic [WIDTH-1:0] flt_val_r;

  // Filtered value follows the synced input only after FILTER_CYCLES stable cycles.
  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      flt_val_r <= '0;
      for (int p = 0; p < WIDTH; p++) flt_cnt_r[p] <= '0;
    end else begin
      for (int p = 0; p < WIDTH; p++) begin
        if (sync_r[SYNC_STAGES-1][p] == flt_val_r[p]) begin
          flt_cnt_r[p] <= '0;
        end else if (flt_cnt_r[p] == FLT_LAST) begin
          flt_val_r[p] <= sync_r[SYNC_STAGES-1][p];
          flt_cnt_r[p] <= '0;
        end else begin
          flt_cnt_r[p] <= flt_cnt_r[p] + FLT_ONE;
        end
      end
    end
  end

  assign in_val_s = flt_val_r;
`else
  assign in_val_s = sync_r[SYNC_STAGES-1];
`endif

  assign core_read = in_val_s;

  // Edge captures are blocked until the input path has flushed its reset contents.
  always_comb begin
    set_s = '0;
    if (arm_state_r == ARMED) begin
      set_s = (in_val_s & ~prev_r & irq_rise_mask) | (~in_val_s & prev_r & irq_fall_mask);
    end else begin
      set_s = '0;
    end
  end

  // Arm state machine, edge history and sticky pending bits (set beats clear).
  always_ff @(posedge io_clock) begin
    if (!io_resetn) begin
      arm_state_r <= DISARMED;
      arm_cnt_r   <= '0;
      prev_r      <= '0;
      irq_pending <= '0;
    end else begin
      prev_r      <= in_val_s;
      irq_pending <= (irq_pending & ~irq_clear) | set_s;
      case (arm_state_r)
        DISARMED: begin
          arm_cnt_r <= arm_cnt_r + CNT_ONE;
          if (arm_cnt_r == ARM_LAST) begin
            arm_state_r <= ARMED;
          end else begin
            arm_state_r <= DISARMED;
          end
        end
        ARMED: begin
          arm_cnt_r   <= arm_cnt_r;
          arm_state_r <= ARMED;
        end
        default: begin
          arm_cnt_r   <= '0;
          arm_state_r <= DISARMED;
        end
      endcase
    end
  end

  assign irq = |irq_pending;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Self-checking bench for gpio_pad_bank (WIDTH=8, SYNC_STAGES=2, FILTER_CYCLES=4),
// comparing against a latency/run-length reference model.
module tb_gpio_pad_bank;

  localparam int W = 8;
  localparam int S = 2;
  localparam int F = 4;
`ifdef GPIO_PAD_BANK_FILTER_EN
  localparam int LAT     = S + F;
  localparam int ARM_LEN = S + 1 + F;
`else
  localparam int LAT     = S;
  localparam int ARM_LEN = S + 1;
`endif

  logic         io_clock = 1'b0;
  logic         io_resetn;
  logic [W-1:0] core_write, core_writeEnable, core_read;
  logic [W-1:0] pad_o, pad_i, pad_t;
  logic [W-1:0] irq_rise_mask, irq_fall_mask, irq_clear, irq_pending;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [W-1:0] m_pad_i, m_pad_t, m_cr, m_prev, m_pend;
  logic [W-1:0] pad_q [$];
  int           m_edges;
`ifdef GPIO_PAD_BANK_FILTER_EN
  logic [W-1:0] m_filt;
  int           m_run [W];
`endif

  gpio_pad_bank #(.WIDTH(W), .SYNC_STAGES(S), .FILTER_CYCLES(F)) dut (
    .io_clock(io_clock), .io_resetn(io_resetn),
    .core_write(core_write), .core_writeEnable(core_writeEnable), .core_read(core_read),
    .pad_o(pad_o), .pad_i(pad_i), .pad_t(pad_t),
    .irq_rise_mask(irq_rise_mask), .irq_fall_mask(irq_fall_mask), .irq_clear(irq_clear),
    .irq_pending(irq_pending), .irq(irq)
  );

  always #5 io_clock = ~io_clock;

  // One clock edge: advance the model with the inputs present at that edge.
  task automatic step();
    logic [W-1:0] set_v;
    logic [W-1:0] synced_old;
    logic [W-1:0] synced_new;
    @(posedge io_clock);
    if (!io_resetn) begin
      m_pad_i = 8'h00; m_pad_t = 8'hFF; m_cr = 8'h00; m_prev = 8'h00; m_pend = 8'h00;
      pad_q.delete();
      m_edges = 0;
`ifdef GPIO_PAD_BANK_FILTER_EN
      m_filt = 8'h00;
      for (int p = 0; p < W; p++) m_run[p] = 0;
`endif
    end else begin
      m_edges++;
      set_v = 8'h00;
      if (m_edges >= ARM_LEN + 1)
        set_v = (m_cr & ~m_prev & irq_rise_mask) | (~m_cr & m_prev & irq_fall_mask);
      m_pend  = (m_pend & ~irq_clear) | set_v;
      m_pad_i = core_write;
      m_pad_t = ~core_writeEnable;
      synced_old = (pad_q.size() == S) ? pad_q[0] : 8'h00;
      pad_q.push_back(pad_o);
      if (pad_q.size() > S) void'(pad_q.pop_front());
      synced_new = (pad_q.size() == S) ? pad_q[0] : 8'h00;
      m_prev = m_cr;
`ifdef GPIO_PAD_BANK_FILTER_EN
      for (int p = 0; p < W; p++) begin
        if (synced_old[p] != m_filt[p]) begin
          m_run[p]++;
          if (m_run[p] == F) begin
            m_filt[p] = synced_old[p];
            m_run[p] = 0;
          end
        end else begin
          m_run[p] = 0;
        end
      end
      m_cr = m_filt;
      if (synced_new === 8'hxx) m_cr = 8'hxx;
`else
      if (synced_old === 8'hxx) m_cr = 8'hxx;
      m_cr = synced_new;
`endif
    end
    #1;
  endtask

  task automatic test_reset();
    io_resetn = 1'b0; pad_o = 8'h00; core_write = 8'h00; core_writeEnable = 8'h00;
    irq_rise_mask = 8'h00; irq_fall_mask = 8'h00; irq_clear = 8'h00;
    repeat (3) step();
    n_tests++; if (pad_t !== 8'hFF) begin n_fail++; $display("FAIL reset_pad_t: got %h expected ff", pad_t); end
    n_tests++; if (pad_i !== 8'h00) begin n_fail++; $display("FAIL reset_pad_i: got %h expected 00", pad_i); end
    n_tests++; if (irq_pending !== 8'h00) begin n_fail++; $display("FAIL reset_pending: got %h expected 00", irq_pending); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    n_tests++; if (core_read !== 8'h00) begin n_fail++; $display("FAIL reset_core_read: got %h expected 00", core_read); end
    io_resetn = 1'b1; core_writeEnable = 8'h01; core_write = 8'h01;
    step();
    n_tests++; if (pad_t[0] !== 1'b0) begin n_fail++; $display("FAIL drive_pad_t0: got %b expected 0", pad_t[0]); end
    n_tests++; if (pad_i[0] !== 1'b1) begin n_fail++; $display("FAIL drive_pad_i0: got %b expected 1", pad_i[0]); end
    n_tests++;
    if ({pad_i, pad_t} !== {m_pad_i, m_pad_t}) begin
      n_fail++; $display("FAIL drive_model: got %h/%h expected %h/%h", pad_i, pad_t, m_pad_i, m_pad_t);
    end
  endtask

  task automatic test_input_latency();
    pad_o = 8'h00; core_writeEnable = 8'h00;
    repeat (ARM_LEN + 2) step();
    irq_rise_mask = 8'h04; pad_o = 8'h05;
    for (int k = 1; k <= LAT; k++) begin
      step();
      n_tests++;
      if (core_read !== ((k == LAT) ? 8'h05 : 8'h00)) begin
        n_fail++; $display("FAIL latency_core_read k=%0d: got %h expected %h", k, core_read, (k == LAT) ? 8'h05 : 8'h00);
      end
      n_tests++; if (irq_pending !== 8'h00) begin n_fail++; $display("FAIL latency_early_pending k=%0d: got %h expected 00", k, irq_pending); end
    end
    step();
    n_tests++; if (irq_pending !== 8'h04) begin n_fail++; $display("FAIL latency_pending: got %h expected 04", irq_pending); end
    n_tests++; if (irq !== 1'b1) begin n_fail++; $display("FAIL latency_irq: got %b expected 1", irq); end
    irq_rise_mask = 8'h00;
  endtask

  task automatic test_disarm();
    io_resetn = 1'b0; pad_o = 8'h08; irq_rise_mask = 8'hFF; irq_fall_mask = 8'h00;
    repeat (2) step();
    io_resetn = 1'b1;
    for (int k = 0; k < ARM_LEN + 6; k++) begin
      step();
      n_tests++; if (irq_pending !== 8'h00) begin n_fail++; $display("FAIL disarm_pending k=%0d: got %h expected 00", k, irq_pending); end
    end
    irq_rise_mask = 8'h00; irq_fall_mask = 8'h08;
    for (int seg = 0; seg < 2; seg++) begin
      pad_o = (seg == 0) ? 8'h00 : 8'h08;
      for (int k = 0; k < LAT + 3; k++) begin
        step();
        n_tests++;
        if (irq_pending !== m_pend) begin n_fail++; $display("FAIL disarm_toggle seg=%0d k=%0d: got %h expected %h", seg, k, irq_pending, m_pend); end
      end
      n_tests++; if (irq_pending !== 8'h08) begin n_fail++; $display("FAIL disarm_fall_only seg=%0d: got %h expected 08", seg, irq_pending); end
    end
  endtask

  task automatic test_clear_collision();
    irq_fall_mask = 8'h00; irq_clear = 8'hFF;
    step();
    irq_clear = 8'h00;
    n_tests++; if (irq_pending !== 8'h00) begin n_fail++; $display("FAIL clear_all: got %h expected 00", irq_pending); end
    pad_o = 8'h00; repeat (LAT + 2) step();
    irq_rise_mask = 8'h04; pad_o = 8'h04; repeat (LAT + 1) step();
    n_tests++; if (irq_pending !== 8'h04) begin n_fail++; $display("FAIL collide_setup: got %h expected 04", irq_pending); end
    pad_o = 8'h00; repeat (LAT + 2) step();
    pad_o = 8'h04; repeat (LAT) step();
    irq_clear = 8'h04;
    step();
    irq_clear = 8'h00;
    n_tests++; if (irq_pending !== 8'h04) begin n_fail++; $display("FAIL collide_set_wins: got %h expected 04", irq_pending); end
    irq_clear = 8'h04;
    step();
    irq_clear = 8'h00;
    n_tests++; if (irq_pending !== 8'h00) begin n_fail++; $display("FAIL clear_no_edge: got %h expected 00", irq_pending); end
    n_tests++; if (irq !== 1'b0) begin n_fail++; $display("FAIL clear_irq_low: got %b expected 0", irq); end
    irq_rise_mask = 8'h00;
  endtask

`ifdef GPIO_PAD_BANK_FILTER_EN
  task automatic test_filter();
    pad_o = 8'h00; irq_rise_mask = 8'h02; irq_fall_mask = 8'h00; irq_clear = 8'hFF;
    repeat (LAT + 2) step();
    irq_clear = 8'h00;
    pad_o = 8'h02; repeat (3) step();
    pad_o = 8'h00;
    for (int k = 0; k < 12; k++) begin
      step();
      n_tests++;
      if (core_read[1] !== 1'b0 || irq_pending !== 8'h00) begin
        n_fail++; $display("FAIL filter_short k=%0d: got %b/%h expected 0/00", k, core_read[1], irq_pending);
      end
    end
    pad_o = 8'h02;
    for (int k = 1; k <= 10; k++) begin
      step();
      n_tests++;
      if (core_read[1] !== (k >= S + F)) begin
        n_fail++; $display("FAIL filter_long k=%0d: got %b expected %b", k, core_read[1], (k >= S + F));
      end
    end
    pad_o = 8'h00; irq_rise_mask = 8'h00;
    repeat (LAT + 2) step();
  endtask
`endif

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        pad_o = 8'($urandom);
        hold = $urandom_range(1, 2 * LAT);
      end else begin
        hold--;
      end
      if ($urandom_range(0, 15) == 0) begin
        irq_rise_mask = 8'($urandom); irq_fall_mask = 8'($urandom);
      end
      irq_clear        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      core_write       = 8'($urandom);
      core_writeEnable = 8'($urandom);
      io_resetn        = ($urandom_range(0, 79) != 0);
      step();
      n_tests++;
      if ({core_read, pad_i, pad_t, irq_pending, irq} !== {m_cr, m_pad_i, m_pad_t, m_pend, |m_pend}) begin
        n_fail++;
        $display("FAIL random c=%0d: got rd=%h pi=%h pt=%h pend=%h irq=%b expected rd=%h pi=%h pt=%h pend=%h irq=%b",
                 c, core_read, pad_i, pad_t, irq_pending, irq, m_cr, m_pad_i, m_pad_t, m_pend, |m_pend);
      end
    end
    io_resetn = 1'b1; irq_clear = 8'h00;
  endtask

  task automatic test_reset_midop();
    irq_rise_mask = 8'hFF; irq_fall_mask = 8'h00; irq_clear = 8'h00;
    pad_o = 8'h00; repeat (ARM_LEN + LAT + 2) step();
    pad_o = 8'hFF; repeat (LAT + 1) step();
    n_tests++; if (irq_pending !== 8'hFF) begin n_fail++; $display("FAIL midop_setup: got %h expected ff", irq_pending); end
    core_writeEnable = 8'hFF; core_write = 8'hAA;
    step();
    n_tests++; if (pad_t !== 8'h00) begin n_fail++; $display("FAIL midop_drive: got %h expected 00", pad_t); end
    io_resetn = 1'b0;
    step();
    n_tests++;
    if ({irq_pending, pad_t, pad_i, irq} !== {8'h00, 8'hFF, 8'h00, 1'b0}) begin
      n_fail++; $display("FAIL midop_reset: got pend=%h pt=%h pi=%h irq=%b expected 00/ff/00/0", irq_pending, pad_t, pad_i, irq);
    end
    io_resetn = 1'b1;
    for (int k = 0; k < ARM_LEN + 4; k++) begin
      step();
      n_tests++; if (irq_pending !== 8'h00) begin n_fail++; $display("FAIL midop_rearm k=%0d: got %h expected 00", k, irq_pending); end
    end
    irq_fall_mask = 8'hFF; pad_o = 8'h00;
    repeat (LAT + 1) step();
    n_tests++; if (irq_pending !== 8'hFF) begin n_fail++; $display("FAIL midop_recapture: got %h expected ff", irq_pending); end
  endtask

  initial begin
    test_reset();
    test_input_latency();
    test_disarm();
    test_clear_collision();
`ifdef GPIO_PAD_BANK_FILTER_EN
    test_filter();
`endif
    test_random();
    test_reset_midop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_pad_bank.md
Name: gpio_pad_bank

Overview:
- Parametrised GPIO pad bank between a GPIO peripheral's read/write/writeEnable bus and an array of board-level tristate IO buffers.
- Registers the output/tristate path and synchronises the input path.
- Adds per-pin rise/fall edge detection with sticky, maskable interrupt-pending bits and one combined interrupt line.
- One instance per GPIO bank in the board top level; replaces hand-instantiated buffer glue with a uniform, width-generic block.

Parameters:
- WIDTH, 32: number of pins in the bank (1..64).
- SYNC_STAGES, 2: input synchroniser depth (2..4).
- FILTER_CYCLES, 4: glitch-filter stability length in clock cycles (1..255). Used only with GPIO_PAD_BANK_FILTER_EN.

Ports:
- io_clock  in  1  bank clock.
- io_resetn  in  1  synchronous reset, active-low.
- core_write  in  WIDTH  output value per pin from the peripheral.
- core_writeEnable  in  WIDTH  per pin; 1 = drive the pad.
- core_read  out  WIDTH  synchronised (optionally filtered) pad value.
- pad_o  in  WIDTH  pad input from buffer O.
- pad_i  out  WIDTH  value driven to buffer I.
- pad_t  out  WIDTH  to buffer T; 1 = high-Z/input, 0 = drive.
- irq_rise_mask  in  WIDTH  per-pin enable for rising-edge capture.
- irq_fall_mask  in  WIDTH  per-pin enable for falling-edge capture.
- irq_clear  in  WIDTH  per-pin clear strobe; write-1-to-clear, 1-cycle pulse.
- irq_pending  out  WIDTH  sticky edge-captured bits.
- irq  out  1  OR-reduce of irq_pending.

Behaviour:
- All state updates on the rising edge of io_clock.
- Reset: io_resetn=0 sampled at a clock edge resets all state.
  - Reset values: pad_i=0, pad_t=all 1s (every pad high-Z), core_read=0, irq_pending=0, irq=0.
  - Synchroniser stages, edge-history register and arm counter are all cleared.
  - Reset asserted mid-operation takes effect at the next edge regardless of in-flight edges; pending bits are lost.
- Output path:
  - pad_i <= core_write and pad_t <= ~core_writeEnable; 1-cycle latency.
  - Drive value and enable change in the same cycle, so there is no glitch window.
- Input path:
  - pad_o passes through a SYNC_STAGES flop chain; core_read = last stage, or the filter output when the filter is enabled.
  - Latency from pad_o change to core_read is exactly SYNC_STAGES cycles without the filter.
  - A pad driven by the bank reads back its own value through the same path.
- Edge detection:
  - prev <= core_read every cycle.
  - rise = core_read & ~prev; fall = ~core_read & prev.
  - set = (rise & irq_rise_mask) | (fall & irq_fall_mask).
  - irq_pending <= (irq_pending & ~irq_clear) | set.
  - Simultaneous set and clear on the same bit: set wins and the bit stays 1.
  - Clearing a mask does not clear an already pending bit.
  - irq is combinational OR of the irq_pending register (no extra latency).
- Arm state machine (after reset release):
  - States are DISARMED and ARMED; reset enters DISARMED.
  - An arm counter counts SYNC_STAGES+1 cycles (+FILTER_CYCLES with the filter), then moves to ARMED.
  - In DISARMED, set is forced to 0 so pins already high at reset release produce no spurious rise.
  - ARMED persists until the next reset.
  - Counter width: $clog2(SYNC_STAGES+FILTER_CYCLES+2); it saturates, with no wrap-around.

Optional Feature:
- GPIO_PAD_BANK_FILTER_EN defined:
  - Per-pin counter, width $clog2(FILTER_CYCLES+1).
  - While the synced input equals the filtered value, the counter is held at 0.
  - While it differs, the counter increments; when it reaches FILTER_CYCLES, the filtered value takes the synced value and the counter resets to 0.
  - Pulses shorter than FILTER_CYCLES cycles never reach core_read or edge logic.
  - Input latency becomes SYNC_STAGES+FILTER_CYCLES cycles.
  - Filtered value resets to 0.
- Undefined: no counters are instantiated; core_read is the synchroniser output directly; the FILTER_CYCLES parameter is ignored.

Test Plan:
- Reset with io_resetn=0 for 3 cycles: pad_t=all 1s, pad_i=0, irq_pending=0, irq=0; then core_writeEnable=0x1, core_write=0x1 -> one cycle later pad_t[0]=0, pad_i[0]=1.
- WIDTH=8, SYNC_STAGES=2, no filter; pad_o 0x00->0x05 at cycle N -> core_read=0x05 at N+2; with irq_rise_mask=0x04, irq_pending=0x04 at N+3 and irq=1.
- pad_o[3] held 1 through reset release with rise mask=0xFF -> irq_pending stays 0 (DISARMED suppression); a later 1->0->1 toggle with fall mask=0x08 sets bit 3 only on the falling edge.
- Pending bit 2 set; assert irq_clear=0x04 in the same cycle a new rise on pin 2 is detected -> irq_pending[2] stays 1; a clear with no new edge -> 0 next cycle, and irq falls.
- GPIO_PAD_BANK_FILTER_EN, FILTER_CYCLES=4: 3-cycle pulse on pad_o[1] -> core_read unchanged, no pending; 10-cycle pulse -> core_read[1] rises exactly SYNC_STAGES+4 cycles after the pad edge.
- Assert io_resetn=0 while irq_pending=0xFF and pads are driven -> next edge: pending=0, pad_t=all 1s, and re-arm completes before new edges are captured.
